// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: registers one request, drives a combinational ALU
// for a single cycle, then holds the response until it is consumed.
module alu_issue_ctrl #(
   parameter bit IMM_ZEXT_LOGIC = 1'b1
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Req_Valid,
   output logic        Req_Ready,
   input  logic [3:0]  Req_Func,
   input  logic [31:0] Req_A,
   input  logic [31:0] Req_B,
   input  logic [15:0] Req_Imm,
   input  logic        Req_UseImm,
   output logic [31:0] Alu_A,
   output logic [31:0] Alu_B,
   output logic [3:0]  Alu_Op,
   input  logic [31:0] Alu_Out,
   input  logic        Alu_Zero,
   output logic        Rsp_Valid,
   input  logic        Rsp_Ready,
   output logic [31:0] Rsp_Data,
   output logic        Rsp_Zero,
   output logic        Rsp_Taken,
   output logic        Rsp_Err,
   output logic [15:0] Op_Count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_DONE
   } state_e;

   localparam logic [3:0] F_AND = 4'd2;
   localparam logic [3:0] F_OR  = 4'd3;
   localparam logic [3:0] F_BEQ = 4'd10;
   localparam logic [3:0] F_BNE = 4'd11;

   state_e      state_q, state_d;
   logic [3:0]  func_q, func_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] data_q, data_d;
   logic        zero_q, zero_d;
   logic        taken_q, taken_d;
   logic        err_q, err_d;
   logic [15:0] cnt_q, cnt_d;

   logic        req_legal;
   logic        req_logic;
   logic [31:0] imm_ext;
   logic [31:0] opnd_b;

   function automatic logic [3:0] op_map(input logic [3:0] f);
      logic [3:0] op;
      op = 4'b0000;
      case (f)
         4'd0:    op = 4'b0000;
         4'd1:    op = 4'b0001;
         4'd2:    op = 4'b0010;
         4'd3:    op = 4'b0011;
         4'd4:    op = 4'b0100;
         4'd5:    op = 4'b1000;
         4'd6:    op = 4'b1001;
         4'd7:    op = 4'b1010;
         4'd8:    op = 4'b1100;
         4'd9:    op = 4'b1101;
         4'd10:   op = 4'b0001;
         4'd11:   op = 4'b0001;
         default: op = 4'b0000;
      endcase
      return op;
   endfunction

   assign req_legal = (Req_Func <= 4'd11);
   assign req_logic = (Req_Func == F_AND) || (Req_Func == F_OR);

   // Logic ops take an unsigned mask immediate when IMM_ZEXT_LOGIC is set
   assign imm_ext = (IMM_ZEXT_LOGIC && req_logic)
                  ? {16'h0000, Req_Imm}
                  : {{16{Req_Imm[15]}}, Req_Imm};
   assign opnd_b  = Req_UseImm ? imm_ext : Req_B;

   always_comb begin
      state_d   = state_q;
      func_d    = func_q;
      a_d       = a_q;
      b_d       = b_q;
      data_d    = data_q;
      zero_d    = zero_q;
      taken_d   = taken_q;
      err_d     = err_q;
      cnt_d     = cnt_q;
      Req_Ready = 1'b0;
      Rsp_Valid = 1'b0;
      Alu_A     = 32'h0;
      Alu_B     = 32'h0;
      Alu_Op    = 4'b0000;
      unique case (state_q)
         S_IDLE: begin
            Req_Ready = 1'b1;
            if (Req_Valid) begin
               func_d  = Req_Func;
               a_d     = Req_A;
               b_d     = opnd_b;
               data_d  = 32'h0;
               zero_d  = 1'b0;
               taken_d = 1'b0;
               err_d   = ~req_legal;
               state_d = req_legal ? S_EXEC : S_DONE;
            end
         end
         S_EXEC: begin
            Alu_A   = a_q;
            Alu_B   = b_q;
            Alu_Op  = op_map(func_q);
            data_d  = Alu_Out;
            zero_d  = Alu_Zero;
            taken_d = ((func_q == F_BEQ) && Alu_Zero) ||
                      ((func_q == F_BNE) && !Alu_Zero);
            state_d = S_DONE;
         end
         S_DONE: begin
            Rsp_Valid = 1'b1;
            if (Rsp_Ready) begin
               cnt_d   = cnt_q + 16'd1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= S_IDLE;
         func_q  <= 4'h0;
         a_q     <= 32'h0;
         b_q     <= 32'h0;
         data_q  <= 32'h0;
         zero_q  <= 1'b0;
         taken_q <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= 16'h0;
      end else begin
         state_q <= state_d;
         func_q  <= func_d;
         a_q     <= a_d;
         b_q     <= b_d;
         data_q  <= data_d;
         zero_q  <= zero_d;
         taken_q <= taken_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign Rsp_Data  = data_q;
   assign Rsp_Zero  = zero_q;
   assign Rsp_Taken = taken_q;
   assign Rsp_Err   = err_q;
   assign Op_Count  = cnt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed cases plus randomized requests,
// checked against a function-level reference model.
module tb_alu_issue_ctrl;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        Req_Valid;
   logic        Req_Ready;
   logic [3:0]  Req_Func;
   logic [31:0] Req_A;
   logic [31:0] Req_B;
   logic [15:0] Req_Imm;
   logic        Req_UseImm;
   logic [31:0] Alu_A;
   logic [31:0] Alu_B;
   logic [3:0]  Alu_Op;
   logic [31:0] Alu_Out;
   logic        Alu_Zero;
   logic        Rsp_Valid;
   logic        Rsp_Ready;
   logic [31:0] Rsp_Data;
   logic        Rsp_Zero;
   logic        Rsp_Taken;
   logic        Rsp_Err;
   logic [15:0] Op_Count;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [15:0] m_cnt = 16'h0;

   always #5 Clk = ~Clk;

   alu_issue_ctrl #(.IMM_ZEXT_LOGIC(1'b1)) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .Req_Valid  (Req_Valid),
      .Req_Ready  (Req_Ready),
      .Req_Func   (Req_Func),
      .Req_A      (Req_A),
      .Req_B      (Req_B),
      .Req_Imm    (Req_Imm),
      .Req_UseImm (Req_UseImm),
      .Alu_A      (Alu_A),
      .Alu_B      (Alu_B),
      .Alu_Op     (Alu_Op),
      .Alu_Out    (Alu_Out),
      .Alu_Zero   (Alu_Zero),
      .Rsp_Valid  (Rsp_Valid),
      .Rsp_Ready  (Rsp_Ready),
      .Rsp_Data   (Rsp_Data),
      .Rsp_Zero   (Rsp_Zero),
      .Rsp_Taken  (Rsp_Taken),
      .Rsp_Err    (Rsp_Err),
      .Op_Count   (Op_Count)
   );

   // Combinational ALU the controller drives
   logic [5:0] sh;
   always_comb begin
      sh = {1'b0, Alu_B[4:0]};
      case (Alu_Op)
         4'b0000: Alu_Out = Alu_A + Alu_B;
         4'b0001: Alu_Out = Alu_A - Alu_B;
         4'b0010: Alu_Out = Alu_A & Alu_B;
         4'b0011: Alu_Out = Alu_A | Alu_B;
         4'b0100: Alu_Out = ~Alu_A;
         4'b1000: Alu_Out = $signed(Alu_A) >>> sh;
         4'b1001: Alu_Out = Alu_A << sh;
         4'b1010: Alu_Out = Alu_A >> sh;
         4'b1100: Alu_Out = (Alu_A << sh) | (Alu_A >> (6'd32 - sh));
         4'b1101: Alu_Out = (Alu_A >> sh) | (Alu_A << (6'd32 - sh));
         default: Alu_Out = 32'h0;
      endcase
      Alu_Zero = (Alu_Out == 32'h0);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] exp_op(input logic [3:0] f);
      logic [3:0] tab [12];
      tab = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b1000,
              4'b1001, 4'b1010, 4'b1100, 4'b1101, 4'b0001, 4'b0001};
      return (f < 4'd12) ? tab[f] : 4'b0000;
   endfunction

   function automatic logic [31:0] exp_b(input logic [3:0] f,
                                         input logic [31:0] b,
                                         input logic [15:0] imm,
                                         input logic u);
      logic [31:0] sx;
      if (!u) return b;
      if (f == 4'd2 || f == 4'd3) return {16'h0, imm};
      sx = {16'h0, imm};
      if (imm[15]) sx = sx - 32'h0001_0000;
      return sx;
   endfunction

   task automatic ref_model(input logic [3:0] f, input logic [31:0] a,
                            input logic [31:0] b, output logic [31:0] d,
                            output logic z, output logic t,
                            output logic e);
      logic [63:0] w;
      int s;
      s = int'(b[4:0]);
      d = 32'h0; t = 1'b0; e = 1'b0;
      case (f)
         4'd0: d = a + b;
         4'd1: d = a - b;
         4'd2: d = a & b;
         4'd3: d = a | b;
         4'd4: d = ~a;
         4'd5: d = (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
         4'd6: d = a << s;
         4'd7: d = a >> s;
         4'd8: begin w = {a, a} << s; d = w[63:32]; end
         4'd9: begin w = {a, a} >> s; d = w[31:0]; end
         4'd10: begin d = a - b; t = (a == b); end
         4'd11: begin d = a - b; t = (a != b); end
         default: e = 1'b1;
      endcase
      z = !e && (d == 32'h0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_rdy"}, {31'h0, Req_Ready}, 32'h1);
      chk({tag, "_rv"}, {31'h0, Rsp_Valid}, 32'h0);
      chk({tag, "_data"}, Rsp_Data, 32'h0);
      chk({tag, "_zte"}, {29'h0, Rsp_Zero, Rsp_Taken, Rsp_Err}, 32'h0);
      chk({tag, "_cnt"}, {16'h0, Op_Count}, 32'h0);
      chk({tag, "_alua"}, Alu_A, 32'h0);
      chk({tag, "_alub"}, Alu_B, 32'h0);
      chk({tag, "_aluop"}, {28'h0, Alu_Op}, 32'h0);
   endtask

   // Starts and ends at a point away from the rising edge with the DUT idle
   task automatic do_req(input logic [3:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [15:0] imm,
                         input logic u, input int hold);
      logic [31:0] be, d;
      logic z, t, e;
      be = exp_b(f, b, imm, u);
      ref_model(f, a, be, d, z, t, e);
      chk("idle_rdy", {31'h0, Req_Ready}, 32'h1);
      chk("idle_rv", {31'h0, Rsp_Valid}, 32'h0);
      Req_Valid = 1'b1; Req_Func = f; Req_A = a;
      Req_B = b; Req_Imm = imm; Req_UseImm = u;
      @(negedge Clk);
      Req_Valid = 1'b0;
      if (!e) begin
         chk("exec_op", {28'h0, Alu_Op}, {28'h0, exp_op(f)});
         chk("exec_a", Alu_A, a);
         chk("exec_b", Alu_B, be);
         chk("exec_rv_rdy", {30'h0, Rsp_Valid, Req_Ready}, 32'h0);
         @(negedge Clk);
      end
      chk("done_rv", {31'h0, Rsp_Valid}, 32'h1);
      chk("done_data", Rsp_Data, d);
      chk("done_zte", {29'h0, Rsp_Zero, Rsp_Taken, Rsp_Err},
          {29'h0, z, t, e});
      chk("done_alu0", Alu_A | Alu_B | {28'h0, Alu_Op}, 32'h0);
      chk("done_rdy", {31'h0, Req_Ready}, 32'h0);
      for (int i = 0; i < hold; i++) begin
         Rsp_Ready = 1'b0;
         Req_Valid = 1'b1; Req_Func = 4'd0; Req_A = 32'h1234;
         @(negedge Clk);
         chk("hold_rv", {31'h0, Rsp_Valid}, 32'h1);
         chk("hold_data", Rsp_Data, d);
         chk("hold_zte", {29'h0, Rsp_Zero, Rsp_Taken, Rsp_Err},
             {29'h0, z, t, e});
         chk("hold_rdy", {31'h0, Req_Ready}, 32'h0);
         chk("hold_cnt", {16'h0, Op_Count}, {16'h0, m_cnt});
      end
      Req_Valid = 1'b0;
      Rsp_Ready = 1'b1;
      @(negedge Clk);
      Rsp_Ready = 1'b0;
      m_cnt = m_cnt + 16'd1;
      chk("post_cnt", {16'h0, Op_Count}, {16'h0, m_cnt});
      chk("post_rv", {31'h0, Rsp_Valid}, 32'h0);
      chk("post_rdy", {31'h0, Req_Ready}, 32'h1);
   endtask

   initial begin
      Reset = 1'b0; Req_Valid = 1'b0; Req_Func = 4'h0; Req_A = 32'h0;
      Req_B = 32'h0; Req_Imm = 16'h0; Req_UseImm = 1'b0; Rsp_Ready = 1'b0;
      repeat (2) @(negedge Clk);
      chk_reset_vals("rst");
      Reset = 1'b1;

      do_req(4'd0, 32'd1, 32'd2, 16'h0, 1'b0, 0);
      do_req(4'd10, 32'h5, 32'h5, 16'h0, 1'b0, 0);
      do_req(4'd11, 32'h5, 32'h5, 16'h0, 1'b0, 0);
      do_req(4'd10, 32'h5, 32'h6, 16'h0, 1'b0, 0);
      do_req(4'd2, 32'hFFFF_FFFF, 32'h0, 16'h8000, 1'b1, 0);
      do_req(4'd0, 32'hFFFF_FFFF, 32'h0, 16'h8000, 1'b1, 0);
      do_req(4'd3, 32'h0, 32'h0, 16'hF00F, 1'b1, 0);
      do_req(4'd5, 32'h8000_0010, 32'd4, 16'h0, 1'b0, 0);
      do_req(4'd8, 32'h8000_0001, 32'd1, 16'h0, 1'b0, 0);
      do_req(4'd9, 32'h0000_0003, 32'd1, 16'h0, 1'b0, 0);
      do_req(4'd1, 32'h7, 32'h7, 16'h0, 1'b0, 5);
      do_req(4'd13, 32'h1, 32'h2, 16'h0, 1'b0, 0);
      do_req(4'd15, 32'h0, 32'h0, 16'h0, 1'b0, 2);

      for (int k = 0; k < 60; k++) begin
         do_req(4'($urandom_range(0, 15)), $urandom, $urandom,
                16'($urandom), 1'($urandom), $urandom_range(0, 2));
      end

      force dut.cnt_q = 16'hFFFF;
      m_cnt = 16'hFFFF;
      #1;
      release dut.cnt_q;
      do_req(4'd12, 32'h0, 32'h0, 16'h0, 1'b0, 0);
      chk("wrap_cnt", {16'h0, Op_Count}, 32'h0);

      Req_Valid = 1'b1; Req_Func = 4'd0; Req_A = 32'h11; Req_B = 32'h22;
      Req_UseImm = 1'b0;
      @(negedge Clk);
      Req_Valid = 1'b0;
      chk("midexec_op", {28'h0, Alu_Op}, 32'h0);
      chk("midexec_a", Alu_A, 32'h11);
      Reset = 1'b0;
      #1;
      m_cnt = 16'h0;
      chk_reset_vals("midrst");
      @(negedge Clk);
      Reset = 1'b1;
      repeat (2) begin
         @(negedge Clk);
         chk("after_rst_rv", {31'h0, Rsp_Valid}, 32'h0);
         chk("after_rst_cnt", {16'h0, Op_Count}, 32'h0);
      end
      do_req(4'd6, 32'h1, 32'd31, 16'h0, 1'b0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
